mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
- Parametrised, registered N-channel multiplexer; successor to the fixed 32:1 single-bit selectors used in the lab datapaths.
- Mode 0 (direct): one channel is read out, chosen by sel.
- Mode 1 (scan): every channel 0..CHANNELS-1 is streamed out in order, one per accepted transfer.
- Output side uses a valid/ready handshake. It feeds serialisers, display drivers and checkers downstream.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 32, number of input channels; any value >= 2, not required to be a power of 2.
- SEL_W, $clog2(CHANNELS), select/channel-index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  flattened channel bus; channel k = data_in[k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel index for mode 0; sampled on the start cycle.
- mode  in  1  0 = direct, 1 = scan; sampled on the start cycle.
- start  in  1  begin operation; honoured only in IDLE.
- out_ready  in  1  downstream accepts out_data when out_valid is high.
- out_data  out  WIDTH  selected channel value, registered.
- out_ch  out  SEL_W  index of the channel in out_data.
- out_valid  out  1  out_data/out_ch hold a beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final beat is accepted.
- sel_err  out  1  one-cycle pulse when a mode-0 start carries sel >= CHANNELS.

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0, sel_err=0; scan counter=0. An in-progress beat is dropped.
- Transfer: occurs on a cycle where out_valid && out_ready.
- Output hold: while out_valid && !out_ready, out_data and out_ch stay stable. data_in changes are ignored until the next load.
- Data sampling: data_in is sampled at the load edge, not at start.
- State IDLE: busy=0.
  - start && mode==0 && sel<CHANNELS: load channel sel into out_data, out_ch=sel, out_valid=1 on the next edge; go to DRAIN. Latency: 1 cycle from start to out_valid.
  - start && mode==0 && sel>=CHANNELS: sel_err=1 for one cycle, no beat is produced, stay in IDLE.
  - start && mode==1: cnt=0; go to SCAN.
- State SCAN: load condition is (!out_valid || out_ready).
  - On a load: out_data=channel cnt, out_ch=cnt, out_valid=1.
  - If cnt==CHANNELS-1, go to DRAIN; otherwise cnt=cnt+1.
  - Back-to-back: with out_ready held high, one beat transfers every cycle. The first beat appears 2 cycles after start.
- State DRAIN: when out_valid && out_ready, clear out_valid, pulse done, go to IDLE.
- Sequence lengths: a mode-1 operation produces exactly CHANNELS beats and a mode-0 operation exactly 1. The done pulse is coincident with the IDLE entry cycle.
- start handling: start while busy is ignored and has no side effects. start in the same cycle as rst is ignored (reset wins).
- out_ready while out_valid=0: no effect.
- Counter: cnt never exceeds CHANNELS-1, and no wrap occurs within a scan.

Decomposition:
- Shared package mux_scan_pkg holds:
  - state enum: IDLE, SCAN, DRAIN (2-bit encoding);
  - mode constants MODE_DIRECT=0, MODE_SCAN=1.
- One combinational sub-module, mux_nto1 (parameters WIDTH, CHANNELS): index-to-channel select, returning 0 for out-of-range indices. It is used for both the sel path and the cnt path through a shared index mux.

Test Plan:
- Reset: rst=1 for 2 cycles mid-scan (after 5 beats) -> all outputs 0, busy=0; the next start runs a full fresh scan beginning at channel 0.
- Direct read: CHANNELS=32, WIDTH=1, data_in=32'hA5A5_0F0F, start with mode=0, sel=9, out_ready=1 -> out_valid high 1 cycle later with out_data=1, out_ch=9; done pulses on that transfer.
- Back-to-back scan: CHANNELS=5, WIDTH=8, channel k=8'h10+k, mode=1, out_ready tied 1 -> 5 consecutive beats with values 10..14 and out_ch 0..4, done on the 5th, busy falls in the next cycle.
- Backpressure: CHANNELS=32, WIDTH=1 scan with out_ready toggling 1,0,0,1 and data_in changing while stalled -> out_data/out_ch stay stable during stalls, no beat is lost or duplicated, 32 transfers in total.
- Out-of-range select: CHANNELS=5, mode=0, sel=6 -> sel_err pulse, out_valid stays 0, busy stays 0.
- Start while busy: pulse start with mode=0 during a scan -> ignored; the scan completes with CHANNELS beats and a single done pulse.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning multiplexer.
//   state_t     : controller states (IDLE, SCAN, DRAIN), 2-bit encoding
//   MODE_DIRECT : read the one channel chosen by sel
//   MODE_SCAN   : stream every channel in ascending order
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_seq_if.sv
// Output beat bus of the scanning multiplexer (valid/ready handshake).
//   out_data  : channel value of the current beat
//   out_ch    : index of the channel carried in out_data
//   out_valid : a beat is being offered
//   out_ready : the consumer takes the beat when out_valid is high
// master = producer (the multiplexer), slave = consumer.
interface mux_scan_seq_if #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 32,
    localparam int SEL_W    = $clog2(CHANNELS)
);
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_nto1.sv
// Combinational N:1 channel selector.
//   idx      : channel index
//   data_in  : flattened channel bus, channel k = data_in[k*WIDTH +: WIDTH]
//   data_out : selected channel, all zeros when idx >= CHANNELS
module mux_nto1 #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 32,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]          idx,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out
);

    // One-hot AND-OR structure: an index with no matching channel yields 0,
    // which gives the out-of-range behaviour for non power-of-2 CHANNELS.
    logic [WIDTH-1:0] masked [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign masked[gi] = (idx == SEL_W'(gi)) ? data_in[gi*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        data_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            data_out = data_out | masked[k];
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Registered N-channel multiplexer with direct and scan modes.
//   clk, rst : clock, synchronous active-high reset
//   data_in  : flattened channel bus, sampled when a beat is loaded
//   sel      : channel for a direct read (sampled on start)
//   mode     : MODE_DIRECT / MODE_SCAN (sampled on start)
//   start    : begin an operation, honoured only when idle
//   busy     : high whenever the controller is not idle
//   done     : one-cycle pulse when the final beat has been accepted
//   sel_err  : one-cycle pulse for a direct start with sel >= CHANNELS
//   out_bus  : output beat stream (valid/ready)
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 32,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      sel_err,
    mux_scan_seq_if.master            out_bus
);

    state_t           state_reg;
    logic [SEL_W-1:0] cnt_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             sel_err_reg;

    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] chan_val;
    logic             sel_ok;
    logic             load_scan;

    // A single selector serves both paths: sel while idle (direct load),
    // the scan counter otherwise.
    assign idx = (state_reg == IDLE) ? sel : cnt_reg;

    mux_nto1 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .idx      (idx),
        .data_in  (data_in),
        .data_out (chan_val)
    );

    // Extra bit so CHANNELS itself is representable when it is a power of 2.
    assign sel_ok    = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
    // Output register is free, or its beat leaves on this edge.
    assign load_scan = !out_valid_reg || out_bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            sel_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_SCAN) begin
                            cnt_reg   <= '0;
                            state_reg <= SCAN;
                            busy_reg  <= 1'b1;
                        end else if (sel_ok) begin
                            out_data_reg  <= chan_val;
                            out_ch_reg    <= sel;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DRAIN;
                            busy_reg      <= 1'b1;
                        end else begin
                            sel_err_reg <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (load_scan) begin
                        out_data_reg  <= chan_val;
                        out_ch_reg    <= cnt_reg;
                        out_valid_reg <= 1'b1;
                        // Counter parks on the last channel; DRAIN hands off
                        // the final beat.
                        if (cnt_reg == SEL_W'(CHANNELS - 1)) begin
                            state_reg <= DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + SEL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_reg && out_bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_bus.out_data  = out_data_reg;
    assign out_bus.out_ch    = out_ch_reg;
    assign out_bus.out_valid = out_valid_reg;
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign sel_err           = sel_err_reg;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed testbench for mux_scan_seq.
// Two instances: dut_a (32 x 1 bit) and dut_b (5 x 8 bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mux_scan_seq;

    localparam int A_CH = 32;
    localparam int A_W  = 1;
    localparam int A_SW = 5;
    localparam int B_CH = 5;
    localparam int B_W  = 8;
    localparam int B_SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- dut_a ----------------
    logic                  rst_a;
    logic [A_CH*A_W-1:0]   data_a;
    logic [A_SW-1:0]       sel_a;
    logic                  mode_a;
    logic                  start_a;
    logic                  busy_a;
    logic                  done_a;
    logic                  sel_err_a;

    mux_scan_seq_if #(.WIDTH(A_W), .CHANNELS(A_CH)) bus_a ();

    mux_scan_seq #(.WIDTH(A_W), .CHANNELS(A_CH)) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .data_in (data_a),
        .sel     (sel_a),
        .mode    (mode_a),
        .start   (start_a),
        .busy    (busy_a),
        .done    (done_a),
        .sel_err (sel_err_a),
        .out_bus (bus_a)
    );

    // ---------------- dut_b ----------------
    logic                  rst_b;
    logic [B_CH*B_W-1:0]   data_b;
    logic [B_SW-1:0]       sel_b;
    logic                  mode_b;
    logic                  start_b;
    logic                  busy_b;
    logic                  done_b;
    logic                  sel_err_b;

    mux_scan_seq_if #(.WIDTH(B_W), .CHANNELS(B_CH)) bus_b ();

    mux_scan_seq #(.WIDTH(B_W), .CHANNELS(B_CH)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .data_in (data_b),
        .sel     (sel_b),
        .mode    (mode_b),
        .start   (start_b),
        .busy    (busy_b),
        .done    (done_b),
        .sel_err (sel_err_b),
        .out_bus (bus_b)
    );

    localparam logic [31:0] BASE_A = 32'hA5A5_0F0F;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Direct read on dut_a; called at a falling edge.
    task automatic direct_a(input logic [A_SW-1:0] s, input logic exp_bit);
        bus_a.out_ready = 1'b1;
        mode_a  = 1'b0;
        sel_a   = s;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        $display("a direct sel=%0d data=%0h ch=%0d", s, bus_a.out_data, bus_a.out_ch);
        check("a_dir_valid", 32'(bus_a.out_valid), 32'd1);
        check("a_dir_data",  32'(bus_a.out_data),  32'(exp_bit));
        check("a_dir_ch",    32'(bus_a.out_ch),    32'(s));
        check("a_dir_busy",  32'(busy_a),          32'd1);
        check("a_dir_done0", 32'(done_a),          32'd0);
        @(negedge clk);
        check("a_dir_done",  32'(done_a),          32'd1);
        check("a_dir_vld0",  32'(bus_a.out_valid), 32'd0);
        check("a_dir_busy0", 32'(busy_a),          32'd0);
        @(negedge clk);
        check("a_dir_done_end", 32'(done_a),       32'd0);
    endtask

    // Full scan on dut_a with out_ready held high; data_a must already be set.
    task automatic scan_a_full();
        logic [31:0] d;
        d = data_a;
        bus_a.out_ready = 1'b1;
        mode_a  = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_scan_gap", 32'(bus_a.out_valid), 32'd0);
        for (int k = 0; k < A_CH; k++) begin
            @(negedge clk);
            $display("a scan beat ch=%0d data=%0h", bus_a.out_ch, bus_a.out_data);
            check("a_scan_valid", 32'(bus_a.out_valid), 32'd1);
            check("a_scan_ch",    32'(bus_a.out_ch),    32'(k));
            check("a_scan_data",  32'(bus_a.out_data),  32'(d[k]));
        end
        @(negedge clk);
        check("a_scan_done", 32'(done_a), 32'd1);
        check("a_scan_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("a_scan_done_end", 32'(done_a), 32'd0);
    endtask

    // Back-to-back scan on dut_b; optionally pulses a direct start mid-scan.
    task automatic scan_b(input bit inject);
        bus_b.out_ready = 1'b1;
        mode_b  = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_scan_gap",  32'(bus_b.out_valid), 32'd0);
        check("b_scan_busy", 32'(busy_b),          32'd1);
        for (int k = 0; k < B_CH; k++) begin
            @(negedge clk);
            $display("b scan beat ch=%0d data=%0h", bus_b.out_ch, bus_b.out_data);
            check("b_scan_valid", 32'(bus_b.out_valid), 32'd1);
            check("b_scan_data",  32'(bus_b.out_data),  32'h10 + 32'(k));
            check("b_scan_ch",    32'(bus_b.out_ch),    32'(k));
            check("b_scan_done0", 32'(done_b),          32'd0);
            if (inject && k == 1) begin
                mode_b  = 1'b0;
                sel_b   = 3'd2;
                start_b = 1'b1;
            end else begin
                start_b = 1'b0;
            end
        end
        @(negedge clk);
        check("b_scan_done",  32'(done_b),          32'd1);
        check("b_scan_busy0", 32'(busy_b),          32'd0);
        check("b_scan_vld0",  32'(bus_b.out_valid), 32'd0);
        @(negedge clk);
        check("b_scan_done_end", 32'(done_b), 32'd0);
        check("b_scan_idle",     32'(busy_b), 32'd0);
    endtask

    // Direct start with an out-of-range select on dut_b.
    task automatic bad_sel_b(input logic [B_SW-1:0] s);
        mode_b  = 1'b0;
        sel_b   = s;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        $display("b direct sel=%0d sel_err=%0d", s, sel_err_b);
        check("b_selerr",      32'(sel_err_b),       32'd1);
        check("b_selerr_vld",  32'(bus_b.out_valid), 32'd0);
        check("b_selerr_busy", 32'(busy_b),          32'd0);
        @(negedge clk);
        check("b_selerr_pulse", 32'(sel_err_b),       32'd0);
        check("b_selerr_vld2",  32'(bus_b.out_valid), 32'd0);
    endtask

    // Scan on dut_a with out_ready cycling 1,0,0,1. Input data is corrupted
    // only for edges where the beat is stalled, so any load during a stall
    // shows up as a wrong value or an unstable output.
    task automatic backpressure_a();
        logic [3:0]      pat;
        logic [31:0]     base;
        int              idx;
        int              dones;
        logic            pv, pr, pd, rn;
        logic [A_SW-1:0] pch;
        pat   = 4'b1001;
        base  = BASE_A;
        idx   = 0;
        dones = 0;
        pv    = 1'b0;
        pr    = 1'b0;
        pd    = 1'b0;
        pch   = '0;
        data_a          = base;
        bus_a.out_ready = 1'b0;
        mode_a          = 1'b1;
        start_a         = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            if (pv && !pr) begin
                check("bp_hold_data", 32'(bus_a.out_data), 32'(pd));
                check("bp_hold_ch",   32'(bus_a.out_ch),   32'(pch));
            end
            if (done_a) dones++;
            rn = pat[cyc[1:0]];
            if (bus_a.out_valid && rn) begin
                $display("bp beat ch=%0d data=%0h", bus_a.out_ch, bus_a.out_data);
                check("bp_ch",   32'(bus_a.out_ch),   32'(idx % 32));
                check("bp_data", 32'(bus_a.out_data), 32'(base[idx % 32]));
                idx++;
            end
            pv  = bus_a.out_valid;
            pr  = rn;
            pd  = bus_a.out_data;
            pch = bus_a.out_ch;
            bus_a.out_ready = rn;
            data_a = (bus_a.out_valid && !rn) ? ~base : base;
            @(negedge clk);
        end
        data_a = base;
        check("bp_transfers", 32'(idx),   32'd32);
        check("bp_done_seen", 32'(dones), 32'd1);
        check("bp_done_end",  32'(done_a), 32'd0);
        check("bp_busy_end",  32'(busy_a), 32'd0);
    endtask

    // Reset dut_a after five beats of a scan, with start asserted during reset.
    task automatic midscan_reset_a();
        data_a          = 32'hFFFF_FFFF;
        bus_a.out_ready = 1'b1;
        mode_a          = 1'b1;
        start_a         = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_pre_ch", 32'(bus_a.out_ch), 32'(k));
        end
        rst_a = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        rst_a   = 1'b0;
        start_a = 1'b0;
        $display("a reset mid-scan valid=%0d ch=%0d busy=%0d", bus_a.out_valid, bus_a.out_ch, busy_a);
        check("rst_valid",   32'(bus_a.out_valid), 32'd0);
        check("rst_data",    32'(bus_a.out_data),  32'd0);
        check("rst_ch",      32'(bus_a.out_ch),    32'd0);
        check("rst_busy",    32'(busy_a),          32'd0);
        check("rst_done",    32'(done_a),          32'd0);
        check("rst_sel_err", 32'(sel_err_a),       32'd0);
        @(negedge clk);
        check("rst_start_ignored", 32'(busy_a), 32'd0);
        data_a = BASE_A;
        scan_a_full();
    endtask

    initial begin
        rst_a = 1'b1;  rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        mode_a = 1'b0;  mode_b = 1'b0;
        sel_a = '0;     sel_b = '0;
        data_a = BASE_A;
        data_b = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("init_a_valid", 32'(bus_a.out_valid), 32'd0);
        check("init_a_data",  32'(bus_a.out_data),  32'd0);
        check("init_a_ch",    32'(bus_a.out_ch),    32'd0);
        check("init_a_busy",  32'(busy_a),          32'd0);
        check("init_a_done",  32'(done_a),          32'd0);
        check("init_b_valid", 32'(bus_b.out_valid), 32'd0);
        check("init_b_busy",  32'(busy_b),          32'd0);
        check("init_b_serr",  32'(sel_err_b),       32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        direct_a(5'd9,  1'b1);
        direct_a(5'd4,  1'b0);
        direct_a(5'd31, 1'b1);

        scan_b(1'b0);
        scan_b(1'b1);

        bad_sel_b(3'd6);
        bad_sel_b(3'd5);

        // In-range direct read on dut_b at the top channel.
        bus_b.out_ready = 1'b1;
        mode_b  = 1'b0;
        sel_b   = 3'd4;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        $display("b direct sel=4 data=%0h ch=%0d", bus_b.out_data, bus_b.out_ch);
        check("b_dir_data",  32'(bus_b.out_data),  32'h14);
        check("b_dir_ch",    32'(bus_b.out_ch),    32'd4);
        check("b_dir_serr",  32'(sel_err_b),       32'd0);
        @(negedge clk);
        check("b_dir_done",  32'(done_b),          32'd1);

        backpressure_a();
        @(negedge clk);
        midscan_reset_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
